// File: rtl/cpu_controller.sv
// cpu_controller: instruction register, decoder and Moore control FSM for the 16-bit RISC datapath.
// Define CTRL_ILLEGAL_TRAP_EN to lock illegal instructions in a TRAP state; otherwise they execute as NOPs.
module cpu_controller (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [2:0]  writenum,
  output logic [2:0]  readnum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [1:0]  vsel,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic        trap
);
`ifdef CTRL_ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG, TRAP} state_t;
`else
  typedef enum logic [2:0] {WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG} state_t;
`endif
  state_t state, next;
  logic [15:0] ir;
  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  logic is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;
  assign opcode = ir[15:13];
  assign op = ir[12:11];
  assign rn = ir[10:8];
  assign rd = ir[7:5];
  assign sh = ir[4:3];
  assign rm = ir[2:0];
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};
  assign is_mov_imm = opcode == 3'b110 && op == 2'b10;
  assign is_mov_reg = opcode == 3'b110 && op == 2'b00;
  assign is_alu = opcode == 3'b101;
  assign is_cmp = is_alu && op == 2'b01;
  assign is_mvn = is_alu && op == 2'b11;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= WAIT;
      ir <= '0;
    end else begin
      state <= next;
      if (load && state == WAIT) ir <= in;
    end
  end
  // Single-operand instructions (MOV reg, MVN) never need the A register, so they skip GET_A.
  always_comb begin
    next = state;
    case (state)
      WAIT:      next = s ? DECODE : WAIT;
      DECODE:    next = is_mov_imm ? WRITE_IMM :
                        (is_alu && !is_mvn) ? GET_A :
                        (is_mov_reg || is_mvn) ? GET_B :
`ifdef CTRL_ILLEGAL_TRAP_EN
                        TRAP;
`else
                        WAIT;
`endif
      WRITE_IMM: next = WAIT;
      GET_A:     next = GET_B;
      GET_B:     next = ALU;
      ALU:       next = is_cmp ? WAIT : WRITE_REG;
      WRITE_REG: next = WAIT;
`ifdef CTRL_ILLEGAL_TRAP_EN
      TRAP:      next = TRAP;
`endif
      default:   next = WAIT;
    endcase
  end
  always_comb begin
    w = state == WAIT;
`ifdef CTRL_ILLEGAL_TRAP_EN
    trap = state == TRAP;
`else
    trap = 1'b0;
`endif
    write = (state == WRITE_IMM) || (state == WRITE_REG);
    writenum = state == WRITE_IMM ? rn : state == WRITE_REG ? rd : 3'd0;
    vsel = state == WRITE_IMM ? 2'b01 : state == WRITE_REG ? 2'b11 : 2'b00;
    loada = state == GET_A;
    loadb = state == GET_B;
    readnum = state == GET_A ? rn : state == GET_B ? rm : 3'd0;
    loadc = state == ALU && !is_cmp;
    loads = state == ALU && is_cmp;
    asel = state == ALU && is_mov_reg;
    bsel = 1'b0;
    shift = state == ALU ? sh : 2'b00;
    ALUop = (state == ALU && is_alu) ? op : 2'b00;
  end
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: random instruction stream against a per-instruction micro-step model with a scoreboard monitor.
module tb_cpu_controller;
  typedef struct packed {
    logic w, trap;
    logic [2:0] writenum, readnum;
    logic write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0] shift, alu_op, vsel;
    logic [15:0] sximm8, sximm5;
  } obs_t;
  logic clk = 0, reset_n = 0, load = 0, s = 0;
  logic [15:0] in = '0;
  logic w, write, loada, loadb, loadc, loads, asel, bsel, trap;
  logic [2:0] writenum, readnum;
  logic [1:0] shift, ALUop, vsel;
  logic [15:0] sximm8, sximm5;
  obs_t sb[$];
  logic [15:0] cur_ir = '0;
  int checks = 0, errors = 0;
  cpu_controller dut (
    .clk(clk), .reset_n(reset_n), .in(in), .load(load), .s(s), .w(w),
    .writenum(writenum), .readnum(readnum), .write(write), .loada(loada),
    .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
    .shift(shift), .ALUop(ALUop), .vsel(vsel), .sximm8(sximm8),
    .sximm5(sximm5), .trap(trap)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] sext(input int v, input int bits);
    if (v >= (1 << (bits - 1))) v -= (1 << bits);
    return 16'(v);
  endfunction
  function automatic obs_t base(input logic [15:0] ir, input logic idle);
    obs_t o = '0;
    o.w = idle;
    o.sximm8 = sext(int'(ir[7:0]), 8);
    o.sximm5 = sext(int'(ir[4:0]), 5);
    return o;
  endfunction
  function automatic obs_t actual();
    obs_t a;
    a.w = w; a.trap = trap; a.writenum = writenum; a.readnum = readnum;
    a.write = write; a.loada = loada; a.loadb = loadb; a.loadc = loadc;
    a.loads = loads; a.asel = asel; a.bsel = bsel; a.shift = shift;
    a.alu_op = ALUop; a.vsel = vsel; a.sximm8 = sximm8; a.sximm5 = sximm5;
    return a;
  endfunction
  // Expected per-edge observations from DECODE through the return to WAIT; returns the edge count.
  task automatic expect_instr(input logic [15:0] ir, input int lim, output int n);
    obs_t q[$];
    obs_t o;
    int opc = int'(ir[15:13]), op = int'(ir[12:11]);
    bit mov_imm = opc == 6 && op == 2, mov_reg = opc == 6 && op == 0, alu = opc == 5;
    bit cmp = alu && op == 1;
    q.push_back(base(ir, 0));
    if (mov_imm) begin
      o = base(ir, 0); o.write = 1; o.writenum = ir[10:8]; o.vsel = 2'b01; q.push_back(o);
    end else if (mov_reg || alu) begin
      if (alu && op != 3) begin
        o = base(ir, 0); o.readnum = ir[10:8]; o.loada = 1; q.push_back(o);
      end
      o = base(ir, 0); o.readnum = ir[2:0]; o.loadb = 1; q.push_back(o);
      o = base(ir, 0); o.shift = ir[4:3]; o.alu_op = mov_reg ? 2'b00 : 2'(op);
      o.asel = mov_reg; o.loadc = !cmp; o.loads = cmp; q.push_back(o);
      if (!cmp) begin
        o = base(ir, 0); o.write = 1; o.writenum = ir[7:5]; o.vsel = 2'b11; q.push_back(o);
      end
    end
    q.push_back(base(ir, 1));
    n = q.size();
    for (int i = 0; i < n && i < lim; i++) sb.push_back(q[i]);
  endtask
  task automatic run(input logic [15:0] ins, input logic do_load);
    int n;
    cur_ir = do_load ? ins : cur_ir;
    in = do_load ? ins : 16'($urandom);
    load = do_load;
    s = 1;
    expect_instr(cur_ir, 99, n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      s = 0;
      load = (k < n) ? 1'($urandom_range(0, 1)) : 1'b0;
      in = (k == 2) ? 16'hD0FB : 16'($urandom);
    end
  endtask
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask
  function automatic logic [15:0] rand_legal();
    int c = $urandom_range(0, 2);
    logic [2:0] opc = c == 2 ? 3'b101 : 3'b110;
    logic [1:0] op = c == 0 ? 2'b10 : c == 1 ? 2'b00 : 2'($urandom_range(0, 3));
    return {opc, op, 11'($urandom)};
  endfunction
  function automatic logic [15:0] rand_illegal();
    logic [2:0] opc;
    logic [1:0] op;
    do begin
      opc = 3'($urandom); op = 2'($urandom);
    end while (opc == 3'b101 || (opc == 3'b110 && (op == 2'b00 || op == 2'b10)));
    return {opc, op, 11'($urandom)};
  endfunction
  initial begin
    obs_t exp0, a;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp0 = sb.pop_front();
        a = actual();
        checks++;
        if (a !== exp0) begin
          errors++;
          $display("FAIL obs t=%0t act=%h exp=%h", $time, a, exp0);
        end
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    #1;
    checks++;
    if (actual() !== base(16'h0, 1)) begin
      errors++;
      $display("FAIL reset_state act=%h exp=%h", actual(), base(16'h0, 1));
    end
    repeat (2) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    run(16'hD0FB, 1);
    run(16'hA148, 1);
    run(16'hA900, 1);
    run(16'hB864, 1);
    run(16'hC5A9, 1);
    run(16'h0000, 0);
`ifndef CTRL_ILLEGAL_TRAP_EN
    run(16'hE000, 1);
`endif
    in = 16'hA9A0; load = 1; s = 0;
    cur_ir = 16'hA9A0;
    sb.push_back(base(cur_ir, 1));
    @(negedge clk);
    run(16'h1234, 0);
    for (int i = 0; i < 40; i++) begin
`ifndef CTRL_ILLEGAL_TRAP_EN
      run($urandom_range(0, 4) == 0 ? rand_illegal() : rand_legal(), 1'($urandom_range(0, 3) != 0));
`else
      run(rand_legal(), 1'($urandom_range(0, 3) != 0));
`endif
    end
    in = 16'hA148; load = 1; s = 1;
    expect_instr(16'hA148, 3, n);
    repeat (3) begin
      @(negedge clk);
      s = 0; load = 0;
    end
    reset_n = 0;
    #1;
    check("abort_w", 16'(w), 16'h1);
    check("abort_loadb", 16'(loadb), 16'h0);
    check("abort_sximm8", sximm8, 16'h0);
    check("abort_sximm5", sximm5, 16'h0);
    @(negedge clk);
    reset_n = 1;
    cur_ir = '0;
    repeat (4) sb.push_back(base(16'h0, 1));
    repeat (4) @(negedge clk);
`ifdef CTRL_ILLEGAL_TRAP_EN
    begin
      obs_t t;
      cur_ir = 16'hE000;
      in = cur_ir; load = 1; s = 1;
      sb.push_back(base(cur_ir, 0));
      t = base(cur_ir, 0); t.trap = 1;
      repeat (4) sb.push_back(t);
      repeat (5) begin
        @(negedge clk);
        s = $urandom_range(0, 1); load = 0;
      end
      reset_n = 0;
      #1;
      check("trap_clear", 16'(trap), 16'h0);
      check("trap_w", 16'(w), 16'h1);
      @(negedge clk);
      reset_n = 1; s = 0;
      @(negedge clk);
    end
`endif
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 16'(sb.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
